// File: rtl/snn_pkg.sv
// Shared constants and FSM state encoding for the spiking conv engine.
//   W_*       : datapath widths
//   DEPTH_*   : filter / ifmap / result side lengths
//   THRESHOLD : integrate-and-fire firing level
package snn_pkg;
    localparam int W_DATA    = 8;
    localparam int W_ADDR    = 12;
    localparam int W_OUT     = 13;
    localparam int DEPTH_F   = 5;
    localparam int DEPTH_I   = 25;
    localparam int DEPTH_R   = DEPTH_I - DEPTH_F + 1;
    localparam int THRESHOLD = 64;

    localparam int N_TAP = DEPTH_F * DEPTH_F;
    localparam int N_IF  = DEPTH_I * DEPTH_I;
    localparam int N_PIX = DEPTH_R * DEPTH_R;

    typedef enum logic [2:0] {
        IDLE, LOAD, START, HDR, COMP, EMIT, DONE
    } state_t;
endpackage

// File: rtl/snn_if_neuron.sv
// Integrate-and-fire neuron update (purely combinational).
//   i_pot   : current membrane potential
//   i_sum   : correlation sum for this timestep
//   o_spike : 1 when pot+sum reaches THRESHOLD
//   o_pot   : next potential (0 after a spike, else pot+sum)
module snn_if_neuron
    import snn_pkg::*;
(
    input  logic [W_OUT-1:0] i_pot,
    input  logic [W_OUT-1:0] i_sum,
    output logic             o_spike,
    output logic [W_OUT-1:0] o_pot
);
    logic [W_OUT-1:0] w_v;

    // 6375 + 63 fits in 13 bits, so the add cannot wrap.
    assign w_v     = i_pot + i_sum;
    assign o_spike = (w_v >= W_OUT'(THRESHOLD));
    assign o_pot   = o_spike ? '0 : w_v;
endmodule

// File: rtl/noc_snn_core.sv
// Single-layer spiking conv engine.
// Load phase : load_start token, filter / ifmap write beats, load_done token.
// Output phase: start_r token, then per timestep a header beat and 441
//               spike beats (one pixel per 26 clocks), then done_r token.
// Ports: clk/rst_n; load_start, filt, ifmap, load_done (inputs with ready);
//        start_r, hdr(ts_r, layer_r), out(out_spike_addr/data), done_r
//        (outputs with valid). All pairs are valid/ready.
module noc_snn_core
    import snn_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start_valid,
    output logic              load_start_ready,
    input  logic              filt_valid,
    output logic              filt_ready,
    input  logic [W_ADDR-1:0] filter_addr,
    input  logic [W_DATA-1:0] filter_data,
    input  logic              ifmap_valid,
    output logic              ifmap_ready,
    input  logic [1:0]        timestep,
    input  logic [W_ADDR-1:0] ifmap_addr,
    input  logic              ifmap_data,
    input  logic              load_done_valid,
    output logic              load_done_ready,
    output logic              start_r_valid,
    input  logic              start_r_ready,
    output logic              start_r,
    output logic              hdr_valid,
    input  logic              hdr_ready,
    output logic [1:0]        ts_r,
    output logic [1:0]        layer_r,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [W_ADDR-1:0] out_spike_addr,
    output logic [W_OUT-1:0]  out_spike_data,
    output logic              done_r_valid,
    input  logic              done_r_ready,
    output logic              done_r
);
    state_t r_state, w_next;

    logic [N_TAP-1:0][W_DATA-1:0] r_filt;
    logic [1:0][N_IF-1:0]         r_ifm;   // plane 0 = ts1, plane 1 = ts2
    logic [N_PIX-1:0][W_OUT-1:0]  r_pot;

    logic [2:0]       r_kr, r_kc;
    logic [4:0]       r_r, r_c;
    logic [8:0]       r_pix;
    logic [1:0]       r_ts;
    logic [W_OUT-1:0] r_sum;
    logic             r_armed;   // keeps load_start_ready low through reset

    logic [4:0]       w_fidx;
    logic [9:0]       w_iidx;
    logic [W_OUT-1:0] w_tap, w_pot_nxt;
    logic             w_spike, w_last_tap, w_last_pix, w_filt_we, w_ifm_we;

    assign w_fidx     = 5'(r_kr) * 5'd5 + 5'(r_kc);
    assign w_iidx     = (10'(r_r) + 10'(r_kr)) * 10'd25 + 10'(r_c) + 10'(r_kc);
    assign w_tap      = r_ifm[r_ts[1]][w_iidx] ? W_OUT'(r_filt[w_fidx]) : '0;
    assign w_last_tap = (r_kr == 3'(DEPTH_F-1)) && (r_kc == 3'(DEPTH_F-1));
    assign w_last_pix = (r_pix == 9'(N_PIX-1));
    // Out-of-range writes are still acknowledged, just not stored.
    assign w_filt_we  = filt_valid && filt_ready && (filter_addr < W_ADDR'(N_TAP));
    assign w_ifm_we   = ifmap_valid && ifmap_ready && (ifmap_addr < W_ADDR'(N_IF))
                        && (timestep == 2'd1 || timestep == 2'd2);

    snn_if_neuron u_neuron (
        .i_pot   (r_pot[r_pix]),
        .i_sum   (r_sum),
        .o_spike (w_spike),
        .o_pot   (w_pot_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next           = r_state;
        load_start_ready = 1'b0;
        filt_ready       = 1'b0;
        ifmap_ready      = 1'b0;
        load_done_ready  = 1'b0;
        start_r_valid    = 1'b0;
        start_r          = 1'b0;
        hdr_valid        = 1'b0;
        ts_r             = '0;
        layer_r          = '0;
        out_valid        = 1'b0;
        out_spike_addr   = '0;
        out_spike_data   = '0;
        done_r_valid     = 1'b0;
        done_r           = 1'b0;
        unique case (r_state)
            IDLE: begin
                load_start_ready = r_armed;
                if (load_start_valid && r_armed) w_next = LOAD;
            end
            LOAD: begin
                filt_ready      = 1'b1;
                ifmap_ready     = 1'b1;
                load_done_ready = 1'b1;
                if (load_done_valid) w_next = START;
            end
            START: begin
                start_r_valid = 1'b1;
                start_r       = 1'b1;
                if (start_r_ready) w_next = HDR;
            end
            HDR: begin
                hdr_valid = 1'b1;
                ts_r      = r_ts;
                layer_r   = 2'd1;
                if (hdr_ready) w_next = COMP;
            end
            COMP: begin
                if (w_last_tap) w_next = EMIT;
            end
            EMIT: begin
                out_valid      = 1'b1;
                out_spike_addr = W_ADDR'(r_pix);
                out_spike_data = W_OUT'(w_spike);
                if (out_ready) begin
                    if (!w_last_pix)         w_next = COMP;
                    else if (r_ts == 2'd2)   w_next = DONE;
                    else                     w_next = HDR;
                end
            end
            DONE: begin
                done_r_valid = 1'b1;
                done_r       = 1'b1;
                if (done_r_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_filt  <= '0;
            r_ifm   <= '0;
            r_pot   <= '0;
            r_kr    <= '0;
            r_kc    <= '0;
            r_r     <= '0;
            r_c     <= '0;
            r_pix   <= '0;
            r_ts    <= 2'd1;
            r_sum   <= '0;
            r_armed <= 1'b0;
        end else begin
            r_armed <= 1'b1;
            if (w_filt_we) r_filt[filter_addr[4:0]] <= filter_data;
            if (w_ifm_we)  r_ifm[timestep[1]][ifmap_addr[9:0]] <= ifmap_data;
            if (start_r_valid && start_r_ready) r_ts <= 2'd1;
            if (hdr_valid && hdr_ready) begin
                if (r_ts == 2'd1) r_pot <= '0;
                r_kr  <= '0;
                r_kc  <= '0;
                r_r   <= '0;
                r_c   <= '0;
                r_pix <= '0;
                r_sum <= '0;
            end
            // One tap per clock, kr outer / kc inner.
            if (r_state == COMP) begin
                r_sum <= r_sum + w_tap;
                if (r_kc == 3'(DEPTH_F-1)) begin
                    r_kc <= '0;
                    r_kr <= w_last_tap ? 3'd0 : r_kr + 3'd1;
                end else begin
                    r_kc <= r_kc + 3'd1;
                end
            end
            // Potential is committed only on accept so the beat stays stable.
            if (out_valid && out_ready) begin
                r_pot[r_pix] <= w_pot_nxt;
                r_sum        <= '0;
                if (w_last_pix) begin
                    r_pix <= '0;
                    r_r   <= '0;
                    r_c   <= '0;
                    r_ts  <= 2'd2;
                end else begin
                    r_pix <= r_pix + 9'd1;
                    if (r_c == 5'(DEPTH_R-1)) begin
                        r_c <= '0;
                        r_r <= r_r + 5'd1;
                    end else begin
                        r_c <= r_c + 5'd1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_noc_snn_core.sv
module tb_noc_snn_core;
    import snn_pkg::*;

    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;

    logic load_start_valid = 0, load_start_ready;
    logic filt_valid = 0, filt_ready;
    logic [11:0] filter_addr = '0;
    logic [7:0]  filter_data = '0;
    logic ifmap_valid = 0, ifmap_ready;
    logic [1:0]  timestep = '0;
    logic [11:0] ifmap_addr = '0;
    logic ifmap_data = 0;
    logic load_done_valid = 0, load_done_ready;
    logic start_r_valid, start_r_ready = 0, start_r;
    logic hdr_valid, hdr_ready = 0;
    logic [1:0] ts_r, layer_r;
    logic out_valid, out_ready = 0;
    logic [11:0] out_spike_addr;
    logic [12:0] out_spike_data;
    logic done_r_valid, done_r_ready = 0, done_r;

    noc_snn_core dut (
        .clk(clk), .rst_n(rst_n),
        .load_start_valid(load_start_valid), .load_start_ready(load_start_ready),
        .filt_valid(filt_valid), .filt_ready(filt_ready),
        .filter_addr(filter_addr), .filter_data(filter_data),
        .ifmap_valid(ifmap_valid), .ifmap_ready(ifmap_ready),
        .timestep(timestep), .ifmap_addr(ifmap_addr), .ifmap_data(ifmap_data),
        .load_done_valid(load_done_valid), .load_done_ready(load_done_ready),
        .start_r_valid(start_r_valid), .start_r_ready(start_r_ready), .start_r(start_r),
        .hdr_valid(hdr_valid), .hdr_ready(hdr_ready), .ts_r(ts_r), .layer_r(layer_r),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_spike_addr(out_spike_addr), .out_spike_data(out_spike_data),
        .done_r_valid(done_r_valid), .done_r_ready(done_r_ready), .done_r(done_r)
    );

    localparam int IF_ZERO = 0, IF_ONE = 1, IF_RND = 2, IF_SINGLE = 3;

    typedef struct {
        string name;
        int    fill;      // value written to every filter tap
        int    tap_k;     // tap overridden with tap_v when tap_v > 0
        int    tap_v;
        int    if1, if2;  // ifmap fill mode per timestep
        bit    bp;        // random out_ready backpressure
        bit    stray;     // add out-of-range writes after the real load
        int    abort_n;   // >0: reset while the abort_n-th beat is pending
        int    exp1, exp2;     // expected spike counts per timestep
        int    exp_addr1;      // expected first ts1 spike address, -1 = none
    } vec_t;

    typedef struct { int ts; int addr; int data; } exp_t;

    vec_t tbl[4];
    exp_t sb[$];
    int   filt[25];
    bit   ifm[2][625];
    int   n_cmp = 0, n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic bit fill_bit(input int mode, input int a);
        case (mode)
            IF_ONE:    return 1'b1;
            IF_RND:    return 1'($urandom_range(0, 1));
            IF_SINGLE: return (a == 26);
            default:   return 1'b0;
        endcase
    endfunction

    // Golden model: plain correlation + integrate-and-fire over both timesteps.
    function automatic void build(input vec_t v);
        int pot[441];
        int s, vv, sp;
        foreach (filt[k]) filt[k] = v.fill;
        if (v.tap_v > 0) filt[v.tap_k] = v.tap_v;
        for (int a = 0; a < 625; a++) begin
            ifm[0][a] = fill_bit(v.if1, a);
            ifm[1][a] = fill_bit(v.if2, a);
        end
        foreach (pot[p]) pot[p] = 0;
        sb.delete();
        for (int t = 0; t < 2; t++)
            for (int r = 0; r < 21; r++)
                for (int c = 0; c < 21; c++) begin
                    s = 0;
                    for (int kr = 0; kr < 5; kr++)
                        for (int kc = 0; kc < 5; kc++)
                            if (ifm[t][(r+kr)*25 + c + kc]) s += filt[kr*5 + kc];
                    vv = pot[r*21+c] + s;
                    sp = (vv >= 64) ? 1 : 0;
                    pot[r*21+c] = sp ? 0 : vv;
                    sb.push_back('{t+1, r*21+c, sp});
                end
    endfunction

    task automatic check_reset(input string tag);
        chk({tag, "_load_start_ready"}, load_start_ready, 0);
        chk({tag, "_filt_ready"}, filt_ready, 0);
        chk({tag, "_ifmap_ready"}, ifmap_ready, 0);
        chk({tag, "_load_done_ready"}, load_done_ready, 0);
        chk({tag, "_start_r_valid"}, start_r_valid, 0);
        chk({tag, "_start_r"}, start_r, 0);
        chk({tag, "_hdr_valid"}, hdr_valid, 0);
        chk({tag, "_ts_r"}, ts_r, 0);
        chk({tag, "_layer_r"}, layer_r, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_addr"}, out_spike_addr, 0);
        chk({tag, "_out_data"}, out_spike_data, 0);
        chk({tag, "_done_r_valid"}, done_r_valid, 0);
        chk({tag, "_done_r"}, done_r, 0);
    endtask

    // Every write is set up at a negedge and transfers on the next posedge.
    task automatic wr_filt(input int a, input int d);
        filter_addr = 12'(a); filter_data = 8'(d); filt_valid = 1;
        @(negedge clk);
        filt_valid = 0;
    endtask

    task automatic wr_ifm(input int t, input int a, input bit d);
        timestep = 2'(t); ifmap_addr = 12'(a); ifmap_data = d; ifmap_valid = 1;
        @(negedge clk);
        ifmap_valid = 0;
    endtask

    task automatic load(input vec_t v);
        int n = 0;
        @(negedge clk);
        load_start_valid = 1;
        while (!load_start_ready && n < 50) begin @(negedge clk); n++; end
        chk("load_start_ready", load_start_ready, 1);
        @(negedge clk);
        load_start_valid = 0;
        chk("filt_ready", filt_ready, 1);
        chk("ifmap_ready", ifmap_ready, 1);
        chk("load_done_ready", load_done_ready, 1);
        for (int k = 0; k < 25; k++) wr_filt(k, 8'hA5);   // overwritten below
        for (int k = 0; k < 25; k++) wr_filt(k, filt[k]);
        for (int t = 0; t < 2; t++)
            for (int a = 0; a < 625; a++) wr_ifm(t + 1, a, ifm[t][a]);
        if (v.stray) begin
            wr_filt(30, 255);
            wr_ifm(3, 0, 1'b1);
            wr_ifm(0, 1, 1'b1);
            wr_ifm(2, 625, 1'b1);
        end
        load_done_valid = 1;
        @(negedge clk);
        load_done_valid = 0;
    endtask

    task automatic run_out(input vec_t v, output bit aborted);
        int cyc = 0, since = 0, n_out = 0, n_hdr = 0, n_start = 0, n_done = 0;
        int sp1 = 0, sp2 = 0, first_sp = -1, cur_ts = 0, nv;
        bit stall = 0, lat_armed = 0, finished = 0;
        int st_addr = 0, st_data = 0;
        exp_t e;
        aborted = 0;
        start_r_ready = 1; hdr_ready = 1; done_r_ready = 1;
        while (cyc < 40000 && !finished) begin
            out_ready = v.bp ? 1'($urandom_range(0, 1)) : 1'b1;
            nv = int'(start_r_valid) + int'(hdr_valid) + int'(out_valid) + int'(done_r_valid);
            if (nv > 1) chk("one_valid_at_a_time", nv, 1);
            if (out_valid) begin
                if (stall) begin
                    chk("hold_addr", out_spike_addr, st_addr);
                    chk("hold_data", out_spike_data, st_data);
                end else if (lat_armed) begin
                    chk("pixel_latency", since, 26);
                    lat_armed = 0;
                end
                if (v.abort_n > 0 && n_out == v.abort_n) begin
                    out_ready = 0;
                    aborted = 1;
                    return;
                end
                if (out_ready) begin
                    if (sb.size() == 0) begin
                        chk("extra_output", n_out, 882);
                    end else begin
                        e = sb.pop_front();
                        chk("out_ts", cur_ts, e.ts);
                        chk("out_addr", out_spike_addr, e.addr);
                        chk("out_data", out_spike_data, e.data);
                    end
                    if (out_spike_data == 13'd1) begin
                        if (cur_ts == 1) begin
                            if (first_sp < 0) first_sp = out_spike_addr;
                            sp1++;
                        end else sp2++;
                    end
                    n_out++;
                    stall = 0; lat_armed = 1; since = 0;
                end else begin
                    stall = 1; st_addr = out_spike_addr; st_data = out_spike_data;
                end
            end
            if (hdr_valid) begin
                n_hdr++;
                chk("hdr_ts", ts_r, n_hdr);
                chk("hdr_layer", layer_r, 1);
                cur_ts = ts_r; lat_armed = 1; since = 0;
            end
            if (start_r_valid) begin
                n_start++;
                chk("start_r", start_r, 1);
            end
            if (done_r_valid) begin
                n_done++;
                chk("done_r", done_r, 1);
                finished = 1;
            end
            @(negedge clk);
            cyc++; since++;
        end
        if (!finished) begin
            n_cmp++; n_bad++;
            $display("FAIL %s_timeout: got %0d outputs, expected done within %0d cycles", v.name, n_out, cyc);
        end
        chk("done_r_valid_cleared", done_r_valid, 0);
        chk("back_to_idle", load_start_ready, 1);
        chk("n_out", n_out, 882);
        chk("n_hdr", n_hdr, 2);
        chk("n_start", n_start, 1);
        chk("n_done", n_done, 1);
        chk("sb_left", sb.size(), 0);
        chk({v.name, "_spikes_ts1"}, sp1, v.exp1);
        chk({v.name, "_spikes_ts2"}, sp2, v.exp2);
        if (v.exp_addr1 >= 0) chk({v.name, "_spike_addr"}, first_sp, v.exp_addr1);
    endtask

    initial begin
        bit ab;
        tbl[0] = '{"zero_abort", 0, 0,   0, IF_RND,    IF_RND,  1'b0, 1'b0, 5, 0,   0,   -1};
        tbl[1] = '{"all3",       3, 0,   0, IF_ONE,    IF_ONE,  1'b0, 1'b0, 0, 441, 441, 0};
        tbl[2] = '{"tap0_40_bp", 0, 0,  40, IF_ONE,    IF_ONE,  1'b1, 1'b0, 0, 0,   441, -1};
        tbl[3] = '{"single_k0",  0, 0, 100, IF_SINGLE, IF_ZERO, 1'b0, 1'b1, 0, 1,   0,   22};

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset("reset");
        rst_n = 1;

        for (int i = 0; i < 4; i++) begin
            build(tbl[i]);
            load(tbl[i]);
            run_out(tbl[i], ab);
            if (ab) begin
                // Async reset lands mid-beat; every valid must drop at once.
                chk("pre_reset_out_valid", out_valid, 1);
                #2 rst_n = 0;
                #1 check_reset("mid_emit_reset");
                @(negedge clk);
                rst_n = 1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
